// File: rtl/npu_layer_seq_if.sv
// Sequencer-to-array/back-end bus: per-layer start pulses, held layer
// configuration, layer completion inputs and the SA psum/valid fabric.
interface npu_layer_seq_if #(
    parameter int SA_COLS    = 16,
    parameter int DATA_WIDTH = 8
);
    logic                          sa_start_o;
    logic                          fc_start_o;
    logic [1:0]                    nth_conv_o;
    logic [4:0]                    ofmap_size_o;
    logic [5:0]                    ifmap_ch_o;
    logic [6:0]                    in_node_num_o;
    logic [6:0]                    out_node_num_o;
    logic                          conv_done_i;
    logic                          fc_done_i;
    logic [SA_COLS*DATA_WIDTH-1:0] psum_i;
    logic [SA_COLS-1:0]            pvalid_i;
    logic [SA_COLS*DATA_WIDTH-1:0] psum_o;
    logic [SA_COLS-1:0]            pvalid_o;

    // Sequencer side
    modport master (
        output sa_start_o, fc_start_o,
        output nth_conv_o, ofmap_size_o, ifmap_ch_o, in_node_num_o, out_node_num_o,
        output psum_o, pvalid_o,
        input  conv_done_i, fc_done_i, psum_i, pvalid_i
    );

    // Array / back-end side
    modport slave (
        input  sa_start_o, fc_start_o,
        input  nth_conv_o, ofmap_size_o, ifmap_ch_o, in_node_num_o, out_node_num_o,
        input  psum_o, pvalid_o,
        output conv_done_i, fc_done_i, psum_i, pvalid_i
    );
endinterface

// File: rtl/npu_layer_seq.sv
// Layer sequencer: walks a host-programmed table of CONV/FC layers, issues
// one start pulse per layer with held configuration, waits for the matching
// completion, and registers the SA psum bus with valids gated to CONV runs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_i; table writable
// LOAD     | copy table[idx] to config outputs, decode mode
// RUN_CONV | CONV layer running; sa_start_o on first cycle; wait conv_done_i
// RUN_FC   | FC layer running; fc_start_o on first cycle; wait fc_done_i
// NEXT     | last layer -> DONE, else advance idx -> LOAD
// DONE     | done_o for one cycle
module npu_layer_seq #(
    parameter int NUM_LAYERS = 8,
    parameter int SA_COLS    = 16,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [1:0]         cfg_mode,
    input  logic [1:0]         cfg_conv_id,
    input  logic [4:0]         cfg_ofmap_size,
    input  logic [5:0]         cfg_ifmap_ch,
    input  logic [6:0]         cfg_in_node,
    input  logic [6:0]         cfg_out_node,
    input  logic [IDX_W:0]     num_layers_i,
    input  logic               start_i,
    input  logic               abort_i,
    npu_layer_seq_if.master    sa_bus,
    output logic               busy_o,
    output logic               done_o,
    output logic [IDX_W-1:0]   layer_idx_o,
    output logic               err_o
);

    localparam logic [IDX_W:0] MAX_LAYERS = (IDX_W+1)'(NUM_LAYERS);
    localparam logic [1:0]     MODE_CONV  = 2'd1;
    localparam logic [1:0]     MODE_FC    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN_CONV,
        S_RUN_FC,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [1:0] tbl_mode     [NUM_LAYERS];
    logic [1:0] tbl_conv_id  [NUM_LAYERS];
    logic [4:0] tbl_ofmap    [NUM_LAYERS];
    logic [5:0] tbl_ifmap_ch [NUM_LAYERS];
    logic [6:0] tbl_in_node  [NUM_LAYERS];
    logic [6:0] tbl_out_node [NUM_LAYERS];

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W:0]   num_q;
    logic             first_q, first_d;
    logic             err_q;

    logic [1:0] nth_conv_q;
    logic [4:0] ofmap_q;
    logic [5:0] ifmap_ch_q;
    logic [6:0] in_node_q;
    logic [6:0] out_node_q;

    logic run_start, bad_start, bad_mode, load_cfg, idx_inc;
    logic num_ok, last_layer;

    assign num_ok     = (num_layers_i != '0) && (num_layers_i <= MAX_LAYERS);
    assign last_layer = ({1'b0, idx_q} == (num_q - (IDX_W+1)'(1)));

    // Host table writes, locked out while a sequence is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                tbl_mode[i]     <= '0;
                tbl_conv_id[i]  <= '0;
                tbl_ofmap[i]    <= '0;
                tbl_ifmap_ch[i] <= '0;
                tbl_in_node[i]  <= '0;
                tbl_out_node[i] <= '0;
            end
        end else if (cfg_we && (state_q == S_IDLE)) begin
            tbl_mode[cfg_idx]     <= cfg_mode;
            tbl_conv_id[cfg_idx]  <= cfg_conv_id;
            tbl_ofmap[cfg_idx]    <= cfg_ofmap_size;
            tbl_ifmap_ch[cfg_idx] <= cfg_ifmap_ch;
            tbl_in_node[cfg_idx]  <= cfg_in_node;
            tbl_out_node[cfg_idx] <= cfg_out_node;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    // Next-state decode; abort overrides everything, including start and done inputs
    always_comb begin
        state_d   = state_q;
        first_d   = 1'b0;
        run_start = 1'b0;
        bad_start = 1'b0;
        bad_mode  = 1'b0;
        load_cfg  = 1'b0;
        idx_inc   = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (num_ok) begin
                            state_d   = S_LOAD;
                            run_start = 1'b1;
                        end else begin
                            bad_start = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    load_cfg = 1'b1;
                    if (tbl_mode[idx_q] == MODE_CONV) begin
                        state_d = S_RUN_CONV;
                        first_d = 1'b1;
                    end else if (tbl_mode[idx_q] == MODE_FC) begin
                        state_d = S_RUN_FC;
                        first_d = 1'b1;
                    end else begin
                        state_d  = S_IDLE;
                        bad_mode = 1'b1;
                    end
                end
                S_RUN_CONV: if (sa_bus.conv_done_i) state_d = S_NEXT;
                S_RUN_FC:   if (sa_bus.fc_done_i)   state_d = S_NEXT;
                S_NEXT: begin
                    if (last_layer) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                        idx_inc = 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore outputs; start pulses only on the first cycle of a RUN state
    always_comb begin
        busy_o            = (state_q != S_IDLE);
        done_o            = (state_q == S_DONE);
        sa_bus.sa_start_o = (state_q == S_RUN_CONV) && first_q;
        sa_bus.fc_start_o = (state_q == S_RUN_FC)   && first_q;
    end

    // Sequence bookkeeping: layer index, latched layer count, sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            num_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (run_start) begin
                idx_q <= '0;
                num_q <= num_layers_i;
            end else if (idx_inc) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (run_start) begin
                err_q <= 1'b0;
            end else if (bad_start || bad_mode) begin
                err_q <= 1'b1;
            end
        end
    end

    // Layer configuration, held from LOAD until the next LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nth_conv_q <= '0;
            ofmap_q    <= '0;
            ifmap_ch_q <= '0;
            in_node_q  <= '0;
            out_node_q <= '0;
        end else if (load_cfg) begin
            nth_conv_q <= tbl_conv_id[idx_q];
            ofmap_q    <= tbl_ofmap[idx_q];
            ifmap_ch_q <= tbl_ifmap_ch[idx_q];
            in_node_q  <= tbl_in_node[idx_q];
            out_node_q <= tbl_out_node[idx_q];
        end
    end

    // Psum fabric: straight register, valids only pass while a CONV layer runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_bus.psum_o   <= '0;
            sa_bus.pvalid_o <= '0;
        end else begin
            sa_bus.psum_o   <= sa_bus.psum_i;
            sa_bus.pvalid_o <= (state_q == S_RUN_CONV) ? sa_bus.pvalid_i : '0;
        end
    end

    assign sa_bus.nth_conv_o     = nth_conv_q;
    assign sa_bus.ofmap_size_o   = ofmap_q;
    assign sa_bus.ifmap_ch_o     = ifmap_ch_q;
    assign sa_bus.in_node_num_o  = in_node_q;
    assign sa_bus.out_node_num_o = out_node_q;
    assign layer_idx_o           = idx_q;
    assign err_o                 = err_q;

endmodule

// File: tb/tb_npu_layer_seq.sv
// Directed bench for npu_layer_seq: multi-layer run, bad mode, bad count,
// abort/replay, psum gating, locked table writes and mid-run reset.
module tb_npu_layer_seq;
    localparam int NL = 8;
    localparam int SC = 16;
    localparam int DW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [1:0]    cfg_mode = '0;
    logic [1:0]    cfg_conv_id = '0;
    logic [4:0]    cfg_ofmap_size = '0;
    logic [5:0]    cfg_ifmap_ch = '0;
    logic [6:0]    cfg_in_node = '0;
    logic [6:0]    cfg_out_node = '0;
    logic [IW:0]   num_layers_i = '0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          busy_o, done_o, err_o;
    logic [IW-1:0] layer_idx_o;

    int n_chk  = 0;
    int n_pass = 0;

    npu_layer_seq_if #(.SA_COLS(SC), .DATA_WIDTH(DW)) sa_bus ();

    npu_layer_seq #(.NUM_LAYERS(NL), .SA_COLS(SC), .DATA_WIDTH(DW), .IDX_W(IW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_mode       (cfg_mode),
        .cfg_conv_id    (cfg_conv_id),
        .cfg_ofmap_size (cfg_ofmap_size),
        .cfg_ifmap_ch   (cfg_ifmap_ch),
        .cfg_in_node    (cfg_in_node),
        .cfg_out_node   (cfg_out_node),
        .num_layers_i   (num_layers_i),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .sa_bus         (sa_bus.master),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .layer_idx_o    (layer_idx_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input int mode, input int id, input int ofm,
                      input int ch, input int inn, input int outn);
        cfg_idx        = idx[IW-1:0];
        cfg_mode       = mode[1:0];
        cfg_conv_id    = id[1:0];
        cfg_ofmap_size = ofm[4:0];
        cfg_ifmap_ch   = ch[5:0];
        cfg_in_node    = inn[6:0];
        cfg_out_node   = outn[6:0];
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    // Entered on the cycle the start pulse is expected; returns on the next
    // layer's pulse cycle (or in IDLE after done_o for the last layer).
    task automatic run_layer(input string nm, input bit is_fc, input int id, input int ofm,
                             input int ch, input int inn, input int outn, input int idx,
                             input int dly, input bit last, input bit stray_other);
        int stray;
        chk({nm, ".sa_start"}, sa_bus.sa_start_o, !is_fc);
        chk({nm, ".fc_start"}, sa_bus.fc_start_o, is_fc);
        chk({nm, ".nth_conv"}, sa_bus.nth_conv_o, id);
        chk({nm, ".ofmap"},    sa_bus.ofmap_size_o, ofm);
        chk({nm, ".ifmap_ch"}, sa_bus.ifmap_ch_o, ch);
        chk({nm, ".in_node"},  sa_bus.in_node_num_o, inn);
        chk({nm, ".out_node"}, sa_bus.out_node_num_o, outn);
        chk({nm, ".idx"},      layer_idx_o, idx);
        stray = 0;
        for (int i = 1; i <= dly; i++) begin
            if (stray_other && i == 2) begin
                if (is_fc) sa_bus.conv_done_i = 1'b1;
                else       sa_bus.fc_done_i   = 1'b1;
            end
            tick();
            sa_bus.conv_done_i = 1'b0;
            sa_bus.fc_done_i   = 1'b0;
            if (sa_bus.sa_start_o || sa_bus.fc_start_o || !busy_o) stray++;
        end
        chk({nm, ".no_stray"}, stray, 0);
        if (is_fc) sa_bus.fc_done_i = 1'b1;
        else       sa_bus.conv_done_i = 1'b1;
        tick();
        sa_bus.conv_done_i = 1'b0;
        sa_bus.fc_done_i   = 1'b0;
        chk({nm, ".next_busy"}, busy_o, 1'b1);
        chk({nm, ".next_done"}, done_o, 1'b0);
        tick();
        if (last) begin
            chk({nm, ".done_pulse"}, done_o, 1'b1);
            chk({nm, ".done_busy"},  busy_o, 1'b1);
            tick();
            chk({nm, ".done_drop"},  done_o, 1'b0);
            chk({nm, ".busy_drop"},  busy_o, 1'b0);
        end else begin
            chk({nm, ".load_done"},  done_o, 1'b0);
            tick();
        end
    endtask

    task automatic start_seq(input int num);
        num_layers_i = num[IW:0];
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        logic [SC*DW-1:0] pat;
        int cnt;
        sa_bus.conv_done_i = 1'b0;
        sa_bus.fc_done_i   = 1'b0;
        sa_bus.psum_i      = '0;
        sa_bus.pvalid_i    = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", busy_o, 1'b0);
        chk("rst.done", done_o, 1'b0);
        chk("rst.err", err_o, 1'b0);
        chk("rst.pvalid", sa_bus.pvalid_o, 16'h0);
        chk("rst.ofmap", sa_bus.ofmap_size_o, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Three-layer run: CONV, CONV, FC; count changed after start has no effect
        wr(0, 1, 0, 28, 1, 0, 0);
        wr(1, 1, 1, 10, 6, 0, 0);
        wr(2, 2, 0, 0, 0, 120, 84);
        start_seq(3);
        num_layers_i = 4'd1;
        chk("A.load_busy", busy_o, 1'b1);
        chk("A.load_nopulse", sa_bus.sa_start_o, 1'b0);
        tick();
        run_layer("A.L0", 1'b0, 0, 28, 1, 0, 0, 0, 20, 1'b0, 1'b0);
        run_layer("A.L1", 1'b0, 1, 10, 6, 0, 0, 1, 20, 1'b0, 1'b0);
        run_layer("A.L2", 1'b1, 0, 0, 0, 120, 84, 2, 20, 1'b1, 1'b1);

        // Psum register and valid gating
        start_seq(1);
        tick();
        pat = '0;
        pat[31:24] = 8'h7F;
        pat[7:0]   = 8'h5A;
        sa_bus.psum_i   = pat;
        sa_bus.pvalid_i = 16'hA5A5;
        tick();
        chk("B.pvalid_conv", sa_bus.pvalid_o, 16'hA5A5);
        chk("B.psum_col3", sa_bus.psum_o[31:24], 8'h7F);
        chk("B.psum_all", sa_bus.psum_o, pat);
        sa_bus.pvalid_i    = '0;
        sa_bus.conv_done_i = 1'b1;
        tick();
        sa_bus.conv_done_i = 1'b0;
        tick();
        chk("B.done", done_o, 1'b1);
        tick();
        chk("B.idle", busy_o, 1'b0);
        pat[31:24] = 8'h11;
        sa_bus.psum_i   = pat;
        sa_bus.pvalid_i = 16'hA5A5;
        tick();
        chk("B.pvalid_idle", sa_bus.pvalid_o, 16'h0);
        chk("B.psum_idle", sa_bus.psum_o, pat);
        sa_bus.pvalid_i = '0;

        // Table write while busy is dropped; rerun with a same-cycle done
        start_seq(1);
        tick();
        wr(0, 2, 3, 5, 9, 1, 2);
        sa_bus.conv_done_i = 1'b1;
        tick();
        sa_bus.conv_done_i = 1'b0;
        repeat (3) tick();
        chk("C.idle", busy_o, 1'b0);
        start_seq(1);
        tick();
        run_layer("C.L0", 1'b0, 0, 28, 1, 0, 0, 0, 0, 1'b1, 1'b0);

        // Zero layer count
        start_seq(0);
        chk("E.err0", err_o, 1'b1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy_o || sa_bus.sa_start_o || sa_bus.fc_start_o) cnt++;
            tick();
        end
        chk("E.quiet0", cnt, 0);

        // Illegal mode in entry 1
        wr(1, 0, 0, 0, 0, 0, 0);
        start_seq(2);
        chk("D.err_clr", err_o, 1'b0);
        tick();
        run_layer("D.L0", 1'b0, 0, 28, 1, 0, 0, 0, 5, 1'b0, 1'b0);
        chk("D.err", err_o, 1'b1);
        chk("D.busy", busy_o, 1'b0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (done_o || sa_bus.sa_start_o || sa_bus.fc_start_o) cnt++;
            tick();
        end
        chk("D.nodone", cnt, 0);

        // Abort during RUN_FC of layer 1, then replay from layer 0
        wr(1, 2, 0, 0, 0, 120, 84);
        start_seq(2);
        tick();
        chk("F.err_clr", err_o, 1'b0);
        run_layer("F.L0", 1'b0, 0, 28, 1, 0, 0, 0, 4, 1'b0, 1'b0);
        chk("F.fc_start", sa_bus.fc_start_o, 1'b1);
        chk("F.idx1", layer_idx_o, 3'd1);
        sa_bus.pvalid_i = 16'hA5A5;
        tick();
        chk("F.pvalid_fc", sa_bus.pvalid_o, 16'h0);
        sa_bus.pvalid_i = '0;
        abort_i = 1'b1;
        sa_bus.fc_done_i = 1'b1;
        tick();
        abort_i = 1'b0;
        sa_bus.fc_done_i = 1'b0;
        chk("F.abort_busy", busy_o, 1'b0);
        chk("F.abort_done", done_o, 1'b0);
        chk("F.keep_in", sa_bus.in_node_num_o, 7'd120);
        chk("F.keep_out", sa_bus.out_node_num_o, 7'd84);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (done_o || busy_o) cnt++;
            tick();
        end
        chk("F.quiet", cnt, 0);
        start_seq(2);
        tick();
        chk("F.replay_idx", layer_idx_o, 3'd0);
        chk("F.replay_sa", sa_bus.sa_start_o, 1'b1);
        chk("F.replay_ofmap", sa_bus.ofmap_size_o, 5'd28);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("F.abort2", busy_o, 1'b0);
        chk("F.err_kept", err_o, 1'b0);

        // Layer count above table depth
        start_seq(NL + 1);
        chk("G.err9", err_o, 1'b1);
        chk("G.busy9", busy_o, 1'b0);
        tick();
        chk("G.nopulse", sa_bus.sa_start_o, 1'b0);

        // Reset mid-run clears outputs and the table
        start_seq(1);
        tick();
        chk("H.running", sa_bus.ofmap_size_o, 5'd28);
        rst_n = 1'b0;
        #1;
        chk("H.busy", busy_o, 1'b0);
        chk("H.ofmap", sa_bus.ofmap_size_o, 5'd0);
        chk("H.sa_start", sa_bus.sa_start_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_seq(1);
        tick();
        chk("H.tbl_cleared_err", err_o, 1'b1);
        chk("H.tbl_cleared_busy", busy_o, 1'b0);
        chk("H.tbl_cleared_sa", sa_bus.sa_start_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
